tf_ram_inferred: RTL and testbench
==================================

// Module: tf_ram_inferred
// PURPOSE
//  Storage array for the UART transmit FIFO: a simple dual-port RAM with one write port and one read port.
//  Writes go to address top; reads come from address bottom.
//  The FIFO controller owns both pointers and the count/overrun logic; this block only stores and returns data.
//  It sits between the TX FIFO controller and the transmitter shift register.
// PARAMETERS
//  fifo_width      8   data word width in bits (UART_FIFO_WIDTH)
//  fifo_depth      16  number of words; must equal 2**fifo_pointer_w
//  fifo_pointer_w  4   address (pointer) width in bits (UART_FIFO_POINTER_W)
// PORTS
//  clk         in   1               single clock; all state updates on posedge
//  fifo_reset  in   1               synchronous, active-high reset
//  we          in   1               write enable; active high; already gated by the controller against full
//  top         in   fifo_pointer_w  write address
//  bottom      in   fifo_pointer_w  read address
//  data_in     in   fifo_width      write data
//  data_out    out  fifo_width      read data = word at bottom
// BEHAVIOUR
//  - Storage: array mem[0..fifo_depth-1] of fifo_width bits.
//  - Reset: on a posedge with fifo_reset=1, every mem word clears to 0.
//    - we is ignored in that cycle; reset has priority over write.
//    - data_out therefore reads 0 from the first cycle after reset.
//  - Write: on a posedge with fifo_reset=0 and we=1, mem[top] <= data_in.
//    - Only one word is written per cycle.
//    - we=0 leaves every word unchanged.
//  - Read (default): data_out = mem[bottom], combinational, with zero latency.
//    - data_out changes in the same cycle that bottom changes.
//  - Same address: with we=1 and top==bottom, data_out shows the old word until the edge and the new word after it.
//    - There is no same-cycle write-through bypass.
//  - Addressing: pointers are modulo fifo_depth by construction, so wrap from 15 to 0 needs no special logic.
//  - Full and empty are not tracked here.
//    - A write to an occupied address overwrites it unconditionally.
//    - Overrun protection is the controller's job (it drops we when count==fifo_depth).
//  - No X propagation: all words are defined after the first reset.
// CONFIGURATION
//  TF_RAM_OUTREG_EN defined:
//    - data_out is registered: data_out <= mem[bottom] at each posedge, giving 1-cycle read latency.
//    - fifo_reset clears the output register to 0 as well as clearing mem.
//    - A same-edge write to mem[bottom] is not visible until the following edge (read-before-write).
//  TF_RAM_OUTREG_EN undefined: combinational read exactly as described in BEHAVIOUR.
// TESTING
//  1. Reset, then write 0xA5 @top=3, set bottom=3:
//     data_out=0xA5 immediately (default) or 1 cycle later (OUTREG).
//  2. Write 16 words 0x10..0x1F @top=0..15, then sweep bottom 0..15:
//     data_out=0x10..0x1F in order; wrap: top=15->0 write 0x77, read @0 gives 0x77.
//  3. we=0 with data_in=0xFF @top=5 (word 5 previously 0x3C):
//     data_out @bottom=5 stays 0x3C.
//  4. we=1 top=bottom=7, old=0x11, new=0x22:
//     data_out=0x11 before the edge, 0x22 after it.
//  5. Fill words with 0xFF, assert fifo_reset together with we=1 data_in=0x55 @top=2:
//     all words read 0x00, including word 2.
//  6. Simultaneous write @top=4 and read sweep @bottom=1..3:
//     reads return prior contents, unaffected by the write.

Source files
------------

// File: rtl/tf_ram_inferred.sv
`default_nettype none
// ============================================================================
//  Module   : tf_ram_inferred
//  Purpose  : Storage array for the UART transmit FIFO. Simple dual-port RAM
//             with one write port (address top) and one read port (address
//             bottom). The FIFO controller owns the pointers, the count and
//             the overrun logic; this block only stores and returns words.
//  Ports    : clk        - single clock, all state updates on posedge
//             fifo_reset - synchronous, active-high; clears every word
//             we         - write enable (already gated against full)
//             top        - write address
//             bottom     - read address
//             data_in    - write data
//             data_out   - read data, word at bottom
//  Options  : TF_RAM_OUTREG_EN - when defined, data_out is registered
//             (1-cycle read latency, read-before-write, cleared by reset).
//             When undefined, data_out is a zero-latency combinational read.
//  Revision : 1.0 - initial release
// ============================================================================
module tf_ram_inferred #(
  parameter int FIFO_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int FIFO_POINTER_W = 4
) (
  input  logic                      clk,
  input  logic                      fifo_reset,
  input  logic                      we,
  input  logic [FIFO_POINTER_W-1:0] top,
  input  logic [FIFO_POINTER_W-1:0] bottom,
  input  logic [FIFO_WIDTH-1:0]     data_in,
  output logic [FIFO_WIDTH-1:0]     data_out
);

  localparam logic [FIFO_WIDTH-1:0] c_ZERO_WORD = '0;

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] mem_d [FIFO_DEPTH];

  // Pointers are exactly FIFO_POINTER_W bits and FIFO_DEPTH == 2**width,
  // so every address is in range and wrap-around needs no handling.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[top] = data_in;
    end
  end

  // Reset takes priority over a write issued in the same cycle.
  always_ff @(posedge clk) begin
    if (fifo_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= c_ZERO_WORD;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

`ifdef TF_RAM_OUTREG_EN
  logic [FIFO_WIDTH-1:0] data_out_q;
  logic [FIFO_WIDTH-1:0] data_out_d;

  // Samples the pre-edge contents, so a same-edge write to mem[bottom]
  // only shows up one edge later.
  always_comb begin
    data_out_d = mem_q[bottom];
  end

  always_ff @(posedge clk) begin
    if (fifo_reset) begin
      data_out_q <= c_ZERO_WORD;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
`else
  // No write-through bypass: a write to mem[bottom] appears after the edge.
  assign data_out = mem_q[bottom];
`endif

endmodule
`default_nettype wire

// File: tb/tb_tf_ram_inferred.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tf_ram_inferred
//  Purpose  : Directed self-checking bench for tf_ram_inferred. Handles both
//             the combinational-read build and the TF_RAM_OUTREG_EN build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tf_ram_inferred;

  logic       clk;
  logic       fifo_reset;
  logic       we;
  logic [3:0] top;
  logic [3:0] bottom;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int n_checks = 0;
  int n_pass   = 0;

  tf_ram_inferred #(
    .FIFO_WIDTH    (8),
    .FIFO_DEPTH    (16),
    .FIFO_POINTER_W(4)
  ) dut (
    .clk       (clk),
    .fifo_reset(fifo_reset),
    .we        (we),
    .top       (top),
    .bottom    (bottom),
    .data_in   (data_in),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are
  // sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input logic [7:0] exp, input string tag);
    n_checks++;
    assert (data_out === exp) n_pass++;
    else $error("FAIL %s: data_out=%h expected=%h", tag, data_out, exp);
  endtask

  task automatic write_word(input logic [3:0] addr, input logic [7:0] val);
    we      = 1'b1;
    top     = addr;
    data_in = val;
    tick();
    we      = 1'b0;
  endtask

  // Present a read address and check the word once it is visible.
  task automatic read_check(input logic [3:0] addr, input logic [7:0] exp,
                            input string tag);
    bottom = addr;
`ifdef TF_RAM_OUTREG_EN
    tick();
`else
    #1;
`endif
    check(exp, tag);
  endtask

  initial begin
    logic [3:0] ptr;
    fifo_reset = 1'b1;
    we         = 1'b0;
    top        = 4'd0;
    bottom     = 4'd0;
    data_in    = 8'h00;
    tick();
    tick();
    fifo_reset = 1'b0;

    // Reset state
    read_check(4'd0,  8'h00, "reset_w0");
    read_check(4'd9,  8'h00, "reset_w9");
    read_check(4'd15, 8'h00, "reset_w15");

    // Test 1: single write then read
    write_word(4'd3, 8'hA5);
    read_check(4'd3, 8'hA5, "t1_write_a5");

    // Test 2: fill all 16 words, sweep, then pointer wrap
    for (int i = 0; i < 16; i++) begin
      write_word(4'(i), 8'(8'h10 + i));
    end
    for (int i = 0; i < 16; i++) begin
      read_check(4'(i), 8'(8'h10 + i), $sformatf("t2_sweep_%0d", i));
    end
    ptr = 4'd15;
    ptr = ptr + 4'd1;
    write_word(ptr, 8'h77);
    read_check(4'd0,  8'h77, "t2_wrap_w0");
    read_check(4'd15, 8'h1F, "t2_wrap_w15");

    // Test 3: we=0 leaves the word untouched
    write_word(4'd5, 8'h3C);
    we      = 1'b0;
    top     = 4'd5;
    data_in = 8'hFF;
    tick();
    read_check(4'd5, 8'h3C, "t3_we0_hold");
    read_check(4'd6, 8'h16, "t3_we0_neighbour");

    // Test 4: same address write/read, no bypass
    write_word(4'd7, 8'h11);
    read_check(4'd7, 8'h11, "t4_old_setup");
    we      = 1'b1;
    top     = 4'd7;
    data_in = 8'h22;
    #1;
    check(8'h11, "t4_before_edge");
    tick();
    we = 1'b0;
`ifdef TF_RAM_OUTREG_EN
    check(8'h11, "t4_rbw_edge");
    tick();
`endif
    check(8'h22, "t4_after_edge");

    // Test 5: reset beats a simultaneous write
    for (int i = 0; i < 16; i++) begin
      write_word(4'(i), 8'hFF);
    end
    read_check(4'd2, 8'hFF, "t5_filled");
    fifo_reset = 1'b1;
    we         = 1'b1;
    top        = 4'd2;
    data_in    = 8'h55;
    tick();
    fifo_reset = 1'b0;
    we         = 1'b0;
    check(8'h00, "t5_out_after_reset");
    for (int i = 0; i < 16; i++) begin
      read_check(4'(i), 8'h00, $sformatf("t5_clear_%0d", i));
    end

    // Test 6: writes to word 4 do not disturb reads of words 1..3
    write_word(4'd1, 8'h31);
    write_word(4'd2, 8'h32);
    write_word(4'd3, 8'h33);
    write_word(4'd4, 8'h40);
    we = 1'b1;
    top = 4'd4;
    for (int i = 1; i <= 3; i++) begin
      data_in = 8'(8'h90 + i);
      bottom  = 4'(i);
`ifdef TF_RAM_OUTREG_EN
      tick();
      check(8'(8'h30 + i), $sformatf("t6_read_%0d", i));
`else
      #1;
      check(8'(8'h30 + i), $sformatf("t6_read_%0d", i));
      tick();
`endif
    end
    we = 1'b0;
`ifdef TF_RAM_OUTREG_EN
    tick();
`endif
    read_check(4'd4, 8'h93, "t6_last_write");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
